// File: rtl/frame_reader_512.sv
// Frame reader behind the 512-deep framing FIFO.
// Waits for a whole frame to be buffered, then bursts it out of the FIFO read
// port and presents it as a valid/ready stream with start and end markers.
// A 3-entry skid buffer absorbs the FIFO's 1-cycle read latency and output
// backpressure. The read strobe never depends on m_ready.
module frame_reader_512 #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAME_LEN   = 512,
  parameter int LEVEL_WIDTH = 10,
  parameter int CNT_WIDTH   = 10
) (
  input  logic                   clk,
  input  logic                   tb_rst,
  input  logic                   frame_enable,
  input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
  input  logic                   fifo_rd_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
  output logic                   fifo_rd_en,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_sof,
  output logic                   m_eof,
  output logic [15:0]            frame_cnt,
  output logic                   busy,
  output logic                   underrun
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0]   FRAME_LEN_C = CNT_WIDTH'(FRAME_LEN);
  localparam logic [CNT_WIDTH-1:0]   LAST_BEAT_C = CNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_GO_C  = LEVEL_WIDTH'(FRAME_LEN);

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf_mem_q [0:2];
  logic [1:0]            buf_wr_ptr_q, buf_rd_ptr_q;
  logic [2:0]            buf_cnt_q, buf_cnt_d;
  logic [15:0]           frame_cnt_q;
  logic                  underrun_q;

  logic issue_open;
  logic rd_en;
  logic push;
  logic pop;
  logic eof_hs;

  function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
    return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
  endfunction

  // Reads are issued only while the frame still owes samples, the FIFO has
  // data, and the buffer can take this read on top of the one in flight.
  assign issue_open = (state_q == ST_BURST) && (issue_cnt_q < FRAME_LEN_C);
  assign rd_en      = issue_open && !fifo_rd_empty &&
                      ((buf_cnt_q + 3'(inflight_q)) <= 3'd2);
  assign push       = inflight_q;
  assign pop        = m_valid && m_ready;
  assign eof_hs     = pop && m_eof;

  assign fifo_rd_en = rd_en;
  assign m_valid    = (buf_cnt_q != 3'd0);
  assign m_data     = buf_mem_q[buf_rd_ptr_q];
  assign m_sof      = m_valid && (beat_cnt_q == '0);
  assign m_eof      = m_valid && (beat_cnt_q == LAST_BEAT_C);
  assign frame_cnt  = frame_cnt_q;
  assign busy       = (state_q != ST_IDLE);
  assign underrun   = underrun_q;

  // Next-state logic for the frame FSM and its issue/beat counters.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    if (pop) begin
      beat_cnt_d = m_eof ? '0 : beat_cnt_q + CNT_WIDTH'(1);
    end
    unique case (state_q)
      ST_IDLE: begin
        issue_cnt_d = '0;
        beat_cnt_d  = '0;
        if (frame_enable && (fifo_rd_water_level >= LEVEL_GO_C)) begin
          state_d = ST_BURST;
        end
      end
      ST_BURST: begin
        if (rd_en) begin
          issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
        end
        if (issue_cnt_q == FRAME_LEN_C) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (eof_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Skid buffer occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    buf_cnt_d = buf_cnt_q;
    unique case ({push, pop})
      2'b10:   buf_cnt_d = buf_cnt_q + 3'd1;
      2'b01:   buf_cnt_d = buf_cnt_q - 3'd1;
      default: buf_cnt_d = buf_cnt_q;
    endcase
  end

  // FSM state, counters, frame count and sticky underrun flag.
  always_ff @(posedge clk or posedge tb_rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    if (tb_rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      frame_cnt_q <= '0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      if (eof_hs) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
      if (issue_open && fifo_rd_empty) begin
        underrun_q <= 1'b1;
      end
    end
  end

  // Read-latency tracking and the 3-entry skid buffer storage.
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      inflight_q   <= 1'b0;
      buf_wr_ptr_q <= 2'd0;
      buf_rd_ptr_q <= 2'd0;
      buf_cnt_q    <= 3'd0;
      // NOTE: the storage is reset because its head drives m_data directly,
      // which must read zero out of reset; it is only three words.
      for (int i = 0; i < 3; i++) begin
        buf_mem_q[i] <= '0;
      end
    end else begin
      inflight_q <= rd_en;
      buf_cnt_q  <= buf_cnt_d;
      if (push) begin
        buf_mem_q[buf_wr_ptr_q] <= fifo_rd_data;
        buf_wr_ptr_q            <= ptr_inc(buf_wr_ptr_q);
      end
      if (pop) begin
        buf_rd_ptr_q <= ptr_inc(buf_rd_ptr_q);
      end
    end
  end

endmodule

// File: tb/tb_frame_reader_512.sv
// Directed bench for frame_reader_512. A behavioural FIFO with 1-cycle read
// latency feeds the reader; a monitor checks every output beat against the
// samples written, plus sof/eof placement and stability under backpressure.
module tb_frame_reader_512;

  localparam int DW = 16;
  localparam int FL = 512;
  localparam int LW = 10;

  logic          clk          = 1'b0;
  logic          tb_rst       = 1'b1;
  logic          frame_enable = 1'b0;
  logic          m_ready      = 1'b1;
  logic          force_empty  = 1'b0;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_rd_empty;
  logic [LW-1:0] fifo_rd_water_level;
  logic          fifo_rd_en;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_sof;
  logic          m_eof;
  logic [15:0]   frame_cnt;
  logic          busy;
  logic          underrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  frame_reader_512 dut (
    .clk                 (clk),
    .tb_rst              (tb_rst),
    .frame_enable        (frame_enable),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_water_level (fifo_rd_water_level),
    .fifo_rd_en          (fifo_rd_en),
    .m_data              (m_data),
    .m_valid             (m_valid),
    .m_ready             (m_ready),
    .m_sof               (m_sof),
    .m_eof               (m_eof),
    .frame_cnt           (frame_cnt),
    .busy                (busy),
    .underrun            (underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural source FIFO: writer owns wr_total, read port owns rd_total.
  logic [15:0] mem [0:1023];
  int wr_total = 0;
  int rd_total = 0;
  int level;
  assign level               = wr_total - rd_total;
  assign fifo_rd_water_level = level[LW-1:0];
  assign fifo_rd_empty       = (level == 0) || force_empty;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rd_data <= mem[rd_total % 1024];
      rd_total     <= rd_total + 1;
    end
  end

  // Output monitor, sampled on the falling edge.
  int          cyc = 0, beat_idx = 0, out_idx = 0, sof_cyc = 0, eof_cyc = 0;
  logic [15:0] sof_data = '0, eof_data = '0, prev_data = '0;
  logic        prev_stall = 1'b0, prev_sof = 1'b0, prev_eof = 1'b0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tb_rst) begin
      beat_idx   <= 0;
      out_idx    <= rd_total;
      prev_stall <= 1'b0;
    end else begin
      check("buf_cnt_le3", 32'(dut.buf_cnt_q <= 3'd3), 32'd1);
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
        check("stall_sof", 32'(m_sof), 32'(prev_sof));
        check("stall_eof", 32'(m_eof), 32'(prev_eof));
      end
      if (m_valid && m_ready) begin
        check("beat_data", 32'(m_data), 32'(mem[out_idx % 1024]));
        check("beat_sof", 32'(m_sof), 32'(beat_idx == 0));
        check("beat_eof", 32'(m_eof), 32'(beat_idx == FL - 1));
        if (beat_idx == 0) begin
          sof_cyc  <= cyc;
          sof_data <= m_data;
        end
        if (beat_idx == FL - 1) begin
          eof_cyc  <= cyc;
          eof_data <= m_data;
          beat_idx <= 0;
        end else begin
          beat_idx <= beat_idx + 1;
        end
        out_idx <= out_idx + 1;
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_sof   <= m_sof;
      prev_eof   <= m_eof;
    end
  end

  // Write one sample, honouring the 512-entry depth of the real FIFO.
  task automatic put(input logic [15:0] v);
    int n = 0;
    @(posedge clk); #1;
    while (level >= FL && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 5000) check("put_space", 32'(level), 32'(FL - 1));
    mem[wr_total % 1024] = v;
    wr_total = wr_total + 1;
  endtask

  task automatic wait_frames(input int target, input string tag);
    int n = 0;
    while (frame_cnt != 16'(target) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(frame_cnt), 32'(target));
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    check({pfx, "_valid"}, 32'(m_valid), 32'd0);
    check({pfx, "_sof"}, 32'(m_sof), 32'd0);
    check({pfx, "_eof"}, 32'(m_eof), 32'd0);
    check({pfx, "_data"}, 32'(m_data), 32'd0);
    check({pfx, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({pfx, "_busy"}, 32'(busy), 32'd0);
    check({pfx, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int base;
    int hold;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("rst");
    tb_rst       = 1'b0;
    frame_enable = 1'b1;
    m_ready      = 1'b1;

    // T1: one frame 0xFFFF downto 0xFE00 at full throughput.
    for (int i = 0; i < FL; i++) put(16'hFFFF - 16'(i));
    wait_frames(1, "t1_frames");
    check("t1_span", 32'(eof_cyc - sof_cyc), 32'(FL - 1));
    check("t1_sof_data", 32'(sof_data), 32'hFFFF);
    check("t1_eof_data", 32'(eof_data), 32'hFE00);
    check("t1_underrun", 32'(underrun), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t1_idle", 32'(busy), 32'd0);

    // T2: 511 samples must not start a frame; the 512th does.
    base = rd_total;
    for (int i = 0; i < FL - 1; i++) put(16'h1000 + 16'(i));
    repeat (20) @(posedge clk);
    #1;
    check("t2_no_reads", 32'(rd_total - base), 32'd0);
    check("t2_not_busy", 32'(busy), 32'd0);
    put(16'h11FF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!busy && n < 20);
    check("t2_start", 32'(busy), 32'd1);
    check("t2_rd_en_e1", 32'(fifo_rd_en), 32'd1);
    check("t2_valid_e1", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t2_valid_e2", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t2_valid_e3", 32'(m_valid), 32'd1);
    check("t2_first_data", 32'(m_data), 32'h1000);
    wait_frames(2, "t2_frames");

    // T3: three back-to-back frames under random backpressure.
    fork
      begin
        for (int i = 0; i < 3 * FL; i++) put(16'h3000 + 16'(i));
      end
      begin
        n = 0;
        while (frame_cnt != 16'd5 && n < 20000) begin
          @(posedge clk); #1;
          m_ready = 1'($urandom_range(0, 1));
          n++;
        end
      end
    join
    m_ready = 1'b1;
    wait_frames(5, "t3_frames");

    // T4: drop enable mid-frame; frame completes, next waits for re-enable.
    base = rd_total;
    fork
      begin
        for (int i = 0; i < 2 * FL; i++) put(16'h2000 + 16'(i));
      end
      begin
        n = 0;
        while (beat_idx != 100 && n < 5000) begin
          @(negedge clk);
          n++;
        end
        check("t4_beat100", 32'(beat_idx), 32'd100);
        @(posedge clk); #1;
        frame_enable = 1'b0;
      end
    join
    wait_frames(6, "t4_frames_a");
    repeat (30) @(posedge clk);
    #1;
    check("t4_held_busy", 32'(busy), 32'd0);
    check("t4_held_cnt", 32'(frame_cnt), 32'd6);
    check("t4_held_level", 32'(level), 32'(FL));
    check("t4_reads", 32'(rd_total - base), 32'(FL));
    frame_enable = 1'b1;
    wait_frames(7, "t4_frames_b");
    check("t4_underrun", 32'(underrun), 32'd0);

    // T5: FIFO falsely empty at issue 200 -> sticky underrun, read stall.
    base = rd_total;
    for (int i = 0; i < FL; i++) put(16'h6000 + 16'(i));
    n = 0;
    while (rd_total - base < 200 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("t5_reach200", 32'(rd_total - base), 32'd200);
    force_empty = 1'b1;
    hold = rd_total;
    repeat (5) @(posedge clk);
    #1;
    check("t5_underrun_set", 32'(underrun), 32'd1);
    check("t5_stalled", 32'(rd_total), 32'(hold));
    check("t5_busy", 32'(busy), 32'd1);
    force_empty = 1'b0;
    wait_frames(8, "t5_frames");
    check("t5_reads", 32'(rd_total - base), 32'(FL));
    check("t5_underrun_sticky", 32'(underrun), 32'd1);

    // T6: asynchronous reset at beat 300, then a clean frame.
    for (int i = 0; i < FL; i++) put(16'h4000 + 16'(i));
    n = 0;
    while (beat_idx != 300 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t6_beat300", 32'(beat_idx), 32'd300);
    #2 tb_rst = 1'b1;
    #1;
    check_zero_outputs("t6_rst");
    wr_total = rd_total;
    repeat (2) @(posedge clk);
    #1;
    tb_rst = 1'b0;
    for (int i = 0; i < FL; i++) put(16'h5000 + 16'(i));
    wait_frames(1, "t6_frames");
    check("t6_sof_data", 32'(sof_data), 32'h5000);
    check("t6_eof_data", 32'(eof_data), 32'h51FF);
    check("t6_underrun", 32'(underrun), 32'd0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
